clb_cfg_emitter: RTL and testbench

- Transmit end of the CLB configuration bitstream.
- Snapshots one CLB configuration record from the configuration controller and emits it as an AXI-stream frame in the exact field order the CLB consumes.
- Per LUT input, in index order 0..LUT_WIDTH-1: a 2-bit type field, then an 8-bit index field. After the last input, the 2**LUT_WIDTH-bit truth table.
- Also drives the CLB `cfg` strobe that starts configuration.

---
 rtl/cfg_pkg.sv | 42 ++++
 rtl/bitstream_writer.sv | 83 ++++++++
 rtl/clb_cfg_emitter.sv | 196 +++++++++++++++++++
 tb/tb_clb_cfg_emitter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_pkg.sv
// Shared definitions for the CLB configuration path.
// The emitter (transmit end) and the CLB-side readers import this package,
// so both ends agree on field widths, the input-type encoding and beat counts.
//   SIGNAL_TYPE_W  : width of the per-input type field
//   SIGNAL_INDEX_W : width of the per-input index field
//   t_input_type   : encoding of the type field
//   t_emit_state   : emitter sequencing states
//   ceil_div       : beats needed to carry a field of a given width
//   cnt_w          : counter width able to index 0..n-1
package cfg_pkg;

  localparam int SIGNAL_TYPE_W  = 2;
  localparam int SIGNAL_INDEX_W = 8;

  typedef enum logic [SIGNAL_TYPE_W-1:0] {
    NEIGHBOUR = 2'd0,
    IO        = 2'd1,
    FEEDBACK  = 2'd2
  } t_input_type;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND_TYPE,
    ST_SEND_INDEX,
    ST_SEND_LUT,
    ST_DONE
  } t_emit_state;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bitstream_writer.sv
// Serialises one configuration field onto an AXI-stream master, LSB first.
// Counterpart of bitstream_reader on the CLB side.
// The field is presented combinationally by the owner (bits, last_beat,
// last_field) and must stay stable while valid is high; the writer only owns
// the beat counter, so consecutive fields follow each other with no bubble.
//   clk, rst       : clock, asynchronous active-high reset
//   start          : clear the beat counter before a new frame
//   valid          : a field is being presented
//   bits           : field contents, zero above the field's real width
//   last_beat      : index of the field's final beat
//   last_field     : this field ends the frame (drives tlast on its final beat)
//   tvalid/tdata/tlast/tready : AXI-stream master
//   ready          : final beat of the field accepted this cycle
module bitstream_writer
  import cfg_pkg::*;
#(
  parameter  int NUM_BITS_TO_WRITE = 16,
  parameter  int DATA_WIDTH        = 1,
  localparam int MAX_BEATS         = ceil_div(NUM_BITS_TO_WRITE, DATA_WIDTH),
  localparam int BEAT_W            = cnt_w(MAX_BEATS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         valid,
  input  logic [NUM_BITS_TO_WRITE-1:0] bits,
  input  logic [BEAT_W-1:0]            last_beat,
  input  logic                         last_field,
  output logic                         tvalid,
  output logic [DATA_WIDTH-1:0]        tdata,
  output logic                         tlast,
  input  logic                         tready,
  output logic                         ready
);

  // Field padded to a whole number of beats so the final slice never reads
  // past the vector; the padding is what zero-fills a short last beat.
  localparam int PAD_W = MAX_BEATS * DATA_WIDTH;

  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [PAD_W-1:0]  padded;
  logic              handshake;
  logic              final_beat;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    padded                         = '0;
    padded[NUM_BITS_TO_WRITE-1:0]  = bits;
    handshake                      = valid & tready;
    final_beat                     = (beat_q == last_beat);
    beat_d                         = beat_q;
    if (start) begin
      beat_d = '0;
    end else if (handshake) begin
      beat_d = final_beat ? '0 : beat_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_q <= '0;
    end else begin
      beat_q <= beat_d;
    end
  end

  // Outputs derive from registered state and the presented field only, so
  // tvalid never depends on tready and tdata/tlast hold while stalled.
  always_comb begin
    tvalid = valid;
    tdata  = '0;
    tlast  = 1'b0;
    ready  = handshake & final_beat;
    if (valid) begin
      tdata = padded[int'(beat_q) * DATA_WIDTH +: DATA_WIDTH];
      tlast = last_field & final_beat;
    end
  end

endmodule

// File: rtl/clb_cfg_emitter.sv
// Transmit end of the CLB configuration bitstream.
// Snapshots one CLB configuration record and emits it as one AXI-stream
// frame: for each LUT input in index order a type field then an index field,
// followed by the truth table. A single bitstream_writer is fed through a
// field mux. Also pulses the CLB cfg strobe while the record is loaded.
//   clk, rst            : clock, asynchronous active-high reset
//   start               : request one frame (honoured only when idle)
//   in_types            : type of input i at [i*SIGNAL_TYPE_W +: SIGNAL_TYPE_W]
//   in_indices          : index of input i at [i*SIGNAL_INDEX_W +: SIGNAL_INDEX_W]
//   in_truth_table      : LUT contents
//   cfg                 : one-cycle strobe to the CLB cfg input
//   cfg_bitstream_*     : AXI-stream master (tvalid/tdata/tlast out, tready in)
//   busy                : from snapshot until the final beat is accepted
//   done                : one-cycle pulse after the final handshake
module clb_cfg_emitter
  import cfg_pkg::*;
#(
  parameter int LUT_WIDTH            = 4,
  parameter int BITSTREAM_DATA_WIDTH = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [LUT_WIDTH*SIGNAL_TYPE_W-1:0]   in_types,
  input  logic [LUT_WIDTH*SIGNAL_INDEX_W-1:0]  in_indices,
  input  logic [2**LUT_WIDTH-1:0]              in_truth_table,
  output logic                                 cfg,
  output logic                                 cfg_bitstream_tvalid,
  output logic [BITSTREAM_DATA_WIDTH-1:0]      cfg_bitstream_tdata,
  output logic                                 cfg_bitstream_tlast,
  input  logic                                 cfg_bitstream_tready,
  output logic                                 busy,
  output logic                                 done
);

  localparam int DW          = BITSTREAM_DATA_WIDTH;
  localparam int TT_W        = 2**LUT_WIDTH;
  localparam int FIELD_W     = max2(max2(SIGNAL_TYPE_W, SIGNAL_INDEX_W), TT_W);
  localparam int MAX_BEATS   = ceil_div(FIELD_W, DW);
  localparam int BEAT_W      = cnt_w(MAX_BEATS);
  localparam int TYPE_BEATS  = ceil_div(SIGNAL_TYPE_W, DW);
  localparam int INDEX_BEATS = ceil_div(SIGNAL_INDEX_W, DW);
  localparam int LUT_BEATS   = ceil_div(TT_W, DW);
  localparam int IDX_W       = cnt_w(LUT_WIDTH);

  localparam logic [IDX_W-1:0]  LAST_INPUT      = IDX_W'(LUT_WIDTH - 1);
  localparam logic [BEAT_W-1:0] TYPE_LAST_BEAT  = BEAT_W'(TYPE_BEATS - 1);
  localparam logic [BEAT_W-1:0] INDEX_LAST_BEAT = BEAT_W'(INDEX_BEATS - 1);
  localparam logic [BEAT_W-1:0] LUT_LAST_BEAT   = BEAT_W'(LUT_BEATS - 1);

  t_emit_state state_q, state_d;
  logic [IDX_W-1:0]                     input_q, input_d;
  logic [LUT_WIDTH*SIGNAL_TYPE_W-1:0]   types_q, types_d;
  logic [LUT_WIDTH*SIGNAL_INDEX_W-1:0]  indices_q, indices_d;
  logic [TT_W-1:0]                      tt_q, tt_d;

  logic                field_valid;
  logic [FIELD_W-1:0]  field_bits;
  logic [BEAT_W-1:0]   field_last_beat;
  logic                field_last;
  logic                field_done;
  logic                writer_start;

  // ---------------------------------------------------------------------------
  // State register (plus the record snapshot and input iterator).
  // NOTE: the snapshot registers are reset too; they are only a few dozen
  // flops and a defined value keeps simulation free of X after reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      input_q   <= '0;
      types_q   <= '0;
      indices_q <= '0;
      tt_q      <= '0;
    end else begin
      state_q   <= state_d;
      input_q   <= input_d;
      types_q   <= types_d;
      indices_q <= indices_d;
      tt_q      <= tt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    input_d   = input_q;
    types_d   = types_q;
    indices_d = indices_q;
    tt_d      = tt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        types_d   = in_types;
        indices_d = in_indices;
        tt_d      = in_truth_table;
        input_d   = '0;
        state_d   = ST_SEND_TYPE;
      end
      ST_SEND_TYPE: begin
        if (field_done) state_d = ST_SEND_INDEX;
      end
      ST_SEND_INDEX: begin
        if (field_done) begin
          if (input_q != LAST_INPUT) begin
            input_d = input_q + 1'b1;
            state_d = ST_SEND_TYPE;
          end else begin
            state_d = ST_SEND_LUT;
          end
        end
      end
      ST_SEND_LUT: begin
        if (field_done) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: strobes and the field mux in front of the writer.
  // ---------------------------------------------------------------------------
  always_comb begin
    cfg             = 1'b0;
    busy            = 1'b0;
    done            = 1'b0;
    writer_start    = 1'b0;
    field_valid     = 1'b0;
    field_bits      = '0;
    field_last_beat = '0;
    field_last      = 1'b0;
    unique case (state_q)
      ST_LOAD: begin
        cfg          = 1'b1;
        busy         = 1'b1;
        writer_start = 1'b1;
      end
      ST_SEND_TYPE: begin
        busy            = 1'b1;
        field_valid     = 1'b1;
        field_bits[SIGNAL_TYPE_W-1:0] =
          types_q[int'(input_q) * SIGNAL_TYPE_W +: SIGNAL_TYPE_W];
        field_last_beat = TYPE_LAST_BEAT;
      end
      ST_SEND_INDEX: begin
        busy            = 1'b1;
        field_valid     = 1'b1;
        field_bits[SIGNAL_INDEX_W-1:0] =
          indices_q[int'(input_q) * SIGNAL_INDEX_W +: SIGNAL_INDEX_W];
        field_last_beat = INDEX_LAST_BEAT;
      end
      ST_SEND_LUT: begin
        busy            = 1'b1;
        field_valid     = 1'b1;
        field_bits[TT_W-1:0] = tt_q;
        field_last_beat = LUT_LAST_BEAT;
        field_last      = 1'b1;
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: begin
        cfg = 1'b0;
      end
    endcase
  end

  bitstream_writer #(
    .NUM_BITS_TO_WRITE (FIELD_W),
    .DATA_WIDTH        (DW)
  ) u_writer (
    .clk        (clk),
    .rst        (rst),
    .start      (writer_start),
    .valid      (field_valid),
    .bits       (field_bits),
    .last_beat  (field_last_beat),
    .last_field (field_last),
    .tvalid     (cfg_bitstream_tvalid),
    .tdata      (cfg_bitstream_tdata),
    .tlast      (cfg_bitstream_tlast),
    .tready     (cfg_bitstream_tready),
    .ready      (field_done)
  );

endmodule

// File: tb/tb_clb_cfg_emitter.sv
// Bench for clb_cfg_emitter: one instance at 1 bit per beat, one at 4 bits
// per beat, sharing clock, reset, start and the record inputs.
module tb_clb_cfg_emitter;

  typedef struct {
    logic [3:0] data;
    logic       last;
  } beat_t;

  typedef struct {
    logic [7:0]  types;
    logic [31:0] indices;
    logic [15:0] tt;
    bit          rand_rdy;
    int          exp_beats1;
    int          exp_beats4;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start;
  logic [7:0]  in_types;
  logic [31:0] in_indices;
  logic [15:0] in_truth_table;

  logic       cfg1, v1, d1, l1, r1, busy1, done1;
  logic       cfg4, v4, l4, r4, busy4, done4;
  logic [3:0] d4;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit rand_rdy = 1'b0;

  beat_t      exp1[$];
  beat_t      exp4[$];
  logic       cap1[$];
  logic [3:0] cap4[$];

  int start_cyc;
  int done_cyc1, done_cyc4, first_cyc1, first_cyc4;
  int cfg_cnt1, cfg_cnt4, cfg_cyc1, cfg_cyc4;
  bit stall1 = 1'b0, stall4 = 1'b0;
  logic       pd1, pl1, pl4;
  logic [3:0] pd4;

  clb_cfg_emitter #(.LUT_WIDTH(4), .BITSTREAM_DATA_WIDTH(1)) dut1 (
    .clk (clk), .rst (rst), .start (start),
    .in_types (in_types), .in_indices (in_indices), .in_truth_table (in_truth_table),
    .cfg (cfg1),
    .cfg_bitstream_tvalid (v1), .cfg_bitstream_tdata (d1),
    .cfg_bitstream_tlast (l1), .cfg_bitstream_tready (r1),
    .busy (busy1), .done (done1)
  );

  clb_cfg_emitter #(.LUT_WIDTH(4), .BITSTREAM_DATA_WIDTH(4)) dut4 (
    .clk (clk), .rst (rst), .start (start),
    .in_types (in_types), .in_indices (in_indices), .in_truth_table (in_truth_table),
    .cfg (cfg4),
    .cfg_bitstream_tvalid (v4), .cfg_bitstream_tdata (d4),
    .cfg_bitstream_tlast (l4), .cfg_bitstream_tready (r4),
    .busy (busy4), .done (done4)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference framing: LSB-first slices of each field, zero past its width.
  task automatic push_field(input int dw, input logic [15:0] val, input int w, input bit last);
    int    nb;
    beat_t b;
    nb = (w + dw - 1) / dw;
    for (int k = 0; k < nb; k++) begin
      b.data = '0;
      for (int j = 0; j < dw; j++)
        if (k * dw + j < w) b.data[j] = val[k * dw + j];
      b.last = last && (k == nb - 1);
      if (dw == 1) exp1.push_back(b);
      else         exp4.push_back(b);
    end
  endtask

  task automatic push_frame(input int dw, input vec_t v);
    for (int i = 0; i < 4; i++) begin
      push_field(dw, 16'(v.types[2*i +: 2]), 2, 1'b0);
      push_field(dw, 16'(v.indices[8*i +: 8]), 8, 1'b0);
    end
    push_field(dw, v.tt, 16, 1'b1);
  endtask

  // Mid-cycle observation of both instances; handshakes seen here complete
  // at the next rising edge because nothing changes in between.
  task automatic monitor();
    beat_t e;
    if (stall1) check("stall_hold_dw1", {v1, l1, d1}, {1'b1, pl1, pd1});
    if (v1 && r1) begin
      if (first_cyc1 < 0) first_cyc1 = cyc;
      check("busy_on_beat_dw1", busy1, 1'b1);
      if (exp1.size() == 0) begin
        total++; bad++;
        $display("FAIL extra_beat_dw1: got beat data=%0h, expected no beat (cycle %0d)", d1, cyc);
      end else begin
        e = exp1.pop_front();
        check("beat_dw1", {l1, d1}, {e.last, e.data[0]});
      end
      cap1.push_back(d1);
    end
    stall1 = v1 && !r1; pd1 = d1; pl1 = l1;
    if (cfg1)  begin cfg_cnt1++; cfg_cyc1 = cyc; end
    if (done1) done_cyc1 = cyc;

    if (stall4) check("stall_hold_dw4", {v4, l4, d4}, {1'b1, pl4, pd4});
    if (v4 && r4) begin
      if (first_cyc4 < 0) first_cyc4 = cyc;
      check("busy_on_beat_dw4", busy4, 1'b1);
      if (exp4.size() == 0) begin
        total++; bad++;
        $display("FAIL extra_beat_dw4: got beat data=%0h, expected no beat (cycle %0d)", d4, cyc);
      end else begin
        e = exp4.pop_front();
        check("beat_dw4", {l4, d4}, {e.last, e.data});
      end
      cap4.push_back(d4);
    end
    stall4 = v4 && !r4; pd4 = d4; pl4 = l4;
    if (cfg4)  begin cfg_cnt4++; cfg_cyc4 = cyc; end
    if (done4) done_cyc4 = cyc;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc++;
    #1;
    r1 = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    r4 = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_tvalid_dw1"}, v1, 1'b0);
    check({tag, "_tlast_dw1"},  l1, 1'b0);
    check({tag, "_tdata_dw1"},  d1, 1'b0);
    check({tag, "_busy_dw1"},   busy1, 1'b0);
    check({tag, "_done_dw1"},   done1, 1'b0);
    check({tag, "_cfg_dw1"},    cfg1, 1'b0);
    check({tag, "_tvalid_dw4"}, v4, 1'b0);
    check({tag, "_tdata_dw4"},  d4, 4'h0);
    check({tag, "_busy_dw4"},   busy4, 1'b0);
  endtask

  // mode 0: plain frame; 1: start pulse mid-frame and record change after
  // LOAD; 2: reset asserted while beat 20 is presented at 1 bit per beat.
  task automatic run_frame(input vec_t v, input int mode);
    int rel;
    in_types       = v.types;
    in_indices     = v.indices;
    in_truth_table = v.tt;
    rand_rdy       = v.rand_rdy;
    push_frame(1, v);
    push_frame(4, v);
    cap1.delete(); cap4.delete();
    done_cyc1 = -1; done_cyc4 = -1; first_cyc1 = -1; first_cyc4 = -1;
    cfg_cnt1 = 0; cfg_cnt4 = 0; cfg_cyc1 = -1; cfg_cyc4 = -1;
    start = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (done_cyc1 >= 0 && done_cyc4 >= 0) break;
      rel = cyc - start_cyc;
      if (mode == 1) begin
        if (rel == 3) in_truth_table = ~v.tt;
        start = (rel == 4);
      end
      if (mode == 2 && rel == 22) begin
        rst = 1'b1;
        #1;
        check("rst_tvalid_drop", v1, 1'b0);
        check("rst_busy_drop",   busy1, 1'b0);
        check("rst_tlast_low",   l1, 1'b0);
        check("rst_beats_before", cap1.size(), 20);
        exp1.delete();
        tick(); tick();
        rst = 1'b0;
        tick();
        return;
      end
      tick();
    end
    start = 1'b0;
    check("frame_done_dw1", done_cyc1 >= 0, 1'b1);
    check("frame_done_dw4", done_cyc4 >= 0, 1'b1);
    check("leftover_dw1", exp1.size(), 0);
    check("leftover_dw4", exp4.size(), 0);
    check("beat_count_dw1", cap1.size(), v.exp_beats1);
    check("beat_count_dw4", cap4.size(), v.exp_beats4);
    check("cfg_pulses_dw1", cfg_cnt1, 1);
    check("cfg_pulses_dw4", cfg_cnt4, 1);
    check("cfg_latency_dw1", cfg_cyc1 - start_cyc, 1);
    check("cfg_latency_dw4", cfg_cyc4 - start_cyc, 1);
    if (!v.rand_rdy) begin
      check("first_beat_latency_dw1", first_cyc1 - start_cyc, 2);
      check("first_beat_latency_dw4", first_cyc4 - start_cyc, 2);
      check("done_latency_dw1", done_cyc1 - start_cyc, 2 + v.exp_beats1);
      check("done_latency_dw4", done_cyc4 - start_cyc, 2 + v.exp_beats4);
    end
    tick();
    check("done_one_cycle_dw1", done1, 1'b0);
    check("busy_after_done_dw1", busy1, 1'b0);
  endtask

  initial begin
    vec_t        vecs[5];
    logic [55:0] gold1, capv1;
    logic [63:0] gold4, capv4;
    int          ones[9];

    vecs[0] = '{8'b10_01_00_00, 32'h03_07_01_00, 16'h8000, 1'b0, 56, 16};
    vecs[1] = '{8'b10_01_00_00, 32'h03_07_01_00, 16'h8000, 1'b1, 56, 16};
    vecs[2] = '{8'b00_10_01_10, 32'hA5_3C_FF_81, 16'h1234, 1'b0, 56, 16};
    vecs[3] = '{8'b10_10_10_10, 32'hFF_FF_FF_FF, 16'hFFFF, 1'b1, 56, 16};
    vecs[4] = '{8'b01_00_10_00, 32'h00_80_00_01, 16'h0001, 1'b1, 56, 16};

    rst = 1'b1; start = 1'b0; r1 = 1'b1; r4 = 1'b1;
    in_types = '0; in_indices = '0; in_truth_table = '0;
    tick(); tick();
    check_idle_outputs("in_reset");
    rst = 1'b0;
    tick(); tick();
    check_idle_outputs("after_reset");

    for (int i = 0; i < 5; i++) begin
      run_frame(vecs[i], 0);
      if (i == 0) begin
        ones  = '{12, 20, 22, 23, 24, 31, 32, 33, 55};
        gold1 = '0;
        foreach (ones[k]) gold1[ones[k]] = 1'b1;
        capv1 = '0;
        for (int k = 0; k < 56 && k < cap1.size(); k++) capv1[k] = cap1[k];
        check("golden_stream_dw1", capv1, gold1);
        gold4 = 64'h8000_0320_7101_0000;
        capv4 = '0;
        for (int k = 0; k < 16 && k < cap4.size(); k++) capv4[4*k +: 4] = cap4[k];
        check("golden_stream_dw4", capv4, gold4);
      end
    end

    // Start ignored mid-frame; truth table changed after the snapshot.
    run_frame(vecs[0], 1);
    for (int n = 0; n < 80; n++) tick();
    check("no_second_frame_cfg_dw1", cfg_cnt1, 1);
    check("no_second_frame_cfg_dw4", cfg_cnt4, 1);
    check("no_second_frame_beats_dw1", cap1.size(), 56);
    check("no_second_frame_beats_dw4", cap4.size(), 16);

    // Reset during beat 20, then a complete fresh frame.
    run_frame(vecs[0], 2);
    check_idle_outputs("post_abort");
    run_frame(vecs[2], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
